// File: rtl/branch_resolve_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : branch_pkg
// Purpose  : Shared types and constants for the branch resolution stage:
//            control-flow op encoding, branch funct3 codes, exception causes
//            and the stage FSM states.
// Revision : 1.0 - initial release
// ============================================================================
package branch_pkg;

  typedef enum logic [1:0] {
    OP_BRANCH = 2'b00,
    OP_JAL    = 2'b01,
    OP_JALR   = 2'b10,
    OP_RSVD   = 2'b11
  } op_e;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [1:0] CAUSE_NONE       = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGNED = 2'b01;
  localparam logic [1:0] CAUSE_ILLEGAL    = 2'b10;

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_SQUASH = 1'b1
  } state_e;

endpackage
`default_nettype wire

// File: rtl/branch_resolve_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : branch_resolve_unit_if
// Purpose  : Bundles the upstream op handshake, the writeback result
//            handshake, the fetch redirect and the statistics counters of the
//            branch resolution stage.
// Revision : 1.0 - initial release
// ============================================================================
interface branch_resolve_unit_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      in_op;
  logic [2:0]      in_funct3;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_imm;
  logic [XLEN-1:0] in_rs1;
  logic            cmp_eq;
  logic            cmp_lt_s;
  logic            cmp_lt_u;
  logic            out_valid;
  logic            out_ready;
  logic            out_rd_we;
  logic [XLEN-1:0] out_link;
  logic            out_exc;
  logic [1:0]      out_cause;
  logic [XLEN-1:0] out_tval;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            squash;
  logic [31:0]     cnt_branch;
  logic [31:0]     cnt_taken;

  // Producer side: issues ops and consumes results.
  modport master (
    output in_valid, in_op, in_funct3, in_pc, in_imm, in_rs1,
           cmp_eq, cmp_lt_s, cmp_lt_u, out_ready,
    input  in_ready, out_valid, out_rd_we, out_link, out_exc, out_cause,
           out_tval, redirect_valid, redirect_pc, squash, cnt_branch, cnt_taken
  );

  // Stage side.
  modport slave (
    input  in_valid, in_op, in_funct3, in_pc, in_imm, in_rs1,
           cmp_eq, cmp_lt_s, cmp_lt_u, out_ready,
    output in_ready, out_valid, out_rd_we, out_link, out_exc, out_cause,
           out_tval, redirect_valid, redirect_pc, squash, cnt_branch, cnt_taken
  );
endinterface
`default_nettype wire

// File: rtl/branch_resolve_unit_cond.sv
`default_nettype none
// ============================================================================
// Module   : branch_cond
// Purpose  : Combinational taken/illegal decision from the op, the branch
//            funct3 and the comparator flags. Illegal ops never report taken.
// Revision : 1.0 - initial release
// ============================================================================
module branch_cond
  import branch_pkg::*;
(
  input  op_e        op_i,
  input  logic [2:0] funct3_i,
  input  logic       cmp_eq_i,
  input  logic       cmp_lt_s_i,
  input  logic       cmp_lt_u_i,
  output logic       taken_o,
  output logic       illegal_o
);

  // Decode branch condition; jumps are unconditional, reserved op is illegal.
  always_comb begin
    taken_o   = 1'b0;
    illegal_o = 1'b0;
    case (op_i)
      OP_BRANCH: begin
        case (funct3_i)
          F3_BEQ:  taken_o = cmp_eq_i;
          F3_BNE:  taken_o = ~cmp_eq_i;
          F3_BLT:  taken_o = cmp_lt_s_i;
          F3_BGE:  taken_o = ~cmp_lt_s_i;
          F3_BLTU: taken_o = cmp_lt_u_i;
          F3_BGEU: taken_o = ~cmp_lt_u_i;
          default: illegal_o = 1'b1;
        endcase
      end
      OP_JAL, OP_JALR: taken_o = 1'b1;
      default:         illegal_o = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module   : branch_resolve_unit
// Purpose  : Registered branch/jump resolution. Decides taken, computes the
//            target and link, raises misaligned/illegal exceptions, pulses a
//            one-cycle fetch redirect and squashes FLUSH_CYCLES accepted
//            wrong-path ops after every taken transfer.
// Revision : 1.0 - initial release
// ============================================================================
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  branch_resolve_unit_if.slave bus
);

  localparam int              CNT_W      = $clog2(FLUSH_CYCLES + 1);
  localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  flush_q, flush_d;

  logic              out_valid_q;
  logic              out_rd_we_q;
  logic [XLEN-1:0]   out_link_q;
  logic              out_exc_q;
  logic [1:0]        out_cause_q;
  logic [XLEN-1:0]   out_tval_q;
  logic              redirect_valid_q;
  logic [XLEN-1:0]   redirect_pc_q;
  logic [31:0]       cnt_branch_q;
  logic [31:0]       cnt_taken_q;

  op_e               w_op;
  logic              w_taken;
  logic              w_illegal;
  logic              w_misaligned;
  logic              w_in_ready;
  logic              w_run_accept;
  logic [XLEN-1:0]   w_br_target;
  logic [XLEN-1:0]   w_jalr_sum;
  logic [XLEN-1:0]   w_target;
  logic [XLEN-1:0]   w_link;

  assign w_op = op_e'(bus.in_op);

  branch_cond u_cond (
    .op_i       (w_op),
    .funct3_i   (bus.in_funct3),
    .cmp_eq_i   (bus.cmp_eq),
    .cmp_lt_s_i (bus.cmp_lt_s),
    .cmp_lt_u_i (bus.cmp_lt_u),
    .taken_o    (w_taken),
    .illegal_o  (w_illegal)
  );

  // JALR clears bit 0 only, so a set bit 1 still reports misaligned.
  assign w_br_target  = bus.in_pc + bus.in_imm;
  assign w_jalr_sum   = bus.in_rs1 + bus.in_imm;
  assign w_target     = (w_op == OP_JALR) ? {w_jalr_sum[XLEN-1:1], 1'b0} : w_br_target;
  assign w_link       = bus.in_pc + XLEN'(4);
  assign w_misaligned = w_taken & (w_target[1:0] != 2'b00);

  // While squashing, wrong-path ops are drained regardless of writeback.
  assign w_in_ready   = (state_q == ST_SQUASH) | ~out_valid_q | bus.out_ready;
  assign w_run_accept = bus.in_valid & w_in_ready & (state_q == ST_RUN);

  // FSM state and squash countdown register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      flush_q <= flush_d;
    end
  end

  // Next state: countdown moves only on accepted (discarded) ops.
  always_comb begin
    state_d = state_q;
    flush_d = flush_q;
    case (state_q)
      ST_RUN: begin
        if (w_run_accept && w_taken) begin
          state_d = ST_SQUASH;
          flush_d = FLUSH_LOAD;
        end
      end
      ST_SQUASH: begin
        if (bus.in_valid) begin
          flush_d = flush_q - CNT_W'(1);
          if (flush_q == CNT_W'(1)) begin
            state_d = ST_RUN;
          end
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Result register, redirect pulse and statistics counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q      <= 1'b0;
      out_rd_we_q      <= 1'b0;
      out_link_q       <= '0;
      out_exc_q        <= 1'b0;
      out_cause_q      <= CAUSE_NONE;
      out_tval_q       <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      cnt_branch_q     <= '0;
      cnt_taken_q      <= '0;
    end else begin
      redirect_valid_q <= w_run_accept & w_taken & ~w_misaligned;
      if (w_run_accept) begin
        out_valid_q <= 1'b1;
        out_link_q  <= w_link;
        out_rd_we_q <= w_taken & ~w_misaligned & ((w_op == OP_JAL) | (w_op == OP_JALR));
        out_exc_q   <= w_illegal | w_misaligned;
        if (w_illegal) begin
          out_cause_q <= CAUSE_ILLEGAL;
          out_tval_q  <= bus.in_pc;
        end else if (w_misaligned) begin
          out_cause_q <= CAUSE_MISALIGNED;
          out_tval_q  <= w_target;
        end else begin
          out_cause_q <= CAUSE_NONE;
          out_tval_q  <= '0;
        end
        if (w_taken && !w_misaligned) begin
          redirect_pc_q <= w_target;
        end
        cnt_branch_q <= cnt_branch_q + 32'd1;
        if (w_taken) begin
          cnt_taken_q <= cnt_taken_q + 32'd1;
        end
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready       = w_in_ready;
  assign bus.out_valid      = out_valid_q;
  assign bus.out_rd_we      = out_rd_we_q;
  assign bus.out_link       = out_link_q;
  assign bus.out_exc        = out_exc_q;
  assign bus.out_cause      = out_cause_q;
  assign bus.out_tval       = out_tval_q;
  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.squash         = (state_q == ST_SQUASH);
  assign bus.cnt_branch     = cnt_branch_q;
  assign bus.cnt_taken      = cnt_taken_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_resolve_unit
// Purpose  : Self-checking bench for branch_resolve_unit: a vector table of
//            ops with hand-computed results, a result scoreboard, and short
//            sequences for stall, backpressure and reset-in-squash cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_resolve_unit;

  localparam int FLUSH = 2;
  localparam int NVEC  = 15;

  typedef struct {
    logic [1:0]  op;
    logic [2:0]  f3;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic        eq;
    logic        lts;
    logic        ltu;
    logic        taken;
    logic        exc;
    logic [1:0]  cause;
    logic [31:0] tval;
    logic        rd_we;
    logic [31:0] link;
    logic        redir;
    logic [31:0] rpc;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  branch_resolve_unit_if #(.XLEN(32)) bus ();

  branch_resolve_unit #(
    .XLEN         (32),
    .FLUSH_CYCLES (FLUSH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          n_total = 0;
  int          n_pass  = 0;
  int          exp_br  = 0;
  int          exp_tk  = 0;
  vec_t        vecs [NVEC];
  vec_t        sb [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic drive(input logic [1:0] op, input logic [2:0] f3, input logic [31:0] pc,
                       input logic [31:0] imm, input logic [31:0] rs1,
                       input logic eq, input logic lts, input logic ltu);
    bus.in_valid  = 1'b1;
    bus.in_op     = op;
    bus.in_funct3 = f3;
    bus.in_pc     = pc;
    bus.in_imm    = imm;
    bus.in_rs1    = rs1;
    bus.cmp_eq    = eq;
    bus.cmp_lt_s  = lts;
    bus.cmp_lt_u  = ltu;
  endtask

  task automatic drive_vec(input vec_t v);
    drive(v.op, v.f3, v.pc, v.imm, v.rs1, v.eq, v.lts, v.ltu);
  endtask

  // Pop the oldest expected result and compare it with the presented result.
  task automatic check_result();
    vec_t e;
    if (sb.size() == 0) begin
      chk("sb_nonempty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk("out_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("out_exc",   {31'd0, bus.out_exc},   {31'd0, e.exc});
      chk("out_cause", {30'd0, bus.out_cause}, {30'd0, e.cause});
      chk("out_tval",  bus.out_tval,           e.tval);
      chk("out_rd_we", {31'd0, bus.out_rd_we}, {31'd0, e.rd_we});
      chk("out_link",  bus.out_link,           e.link);
    end
  endtask

  task automatic check_counters(input string tag);
    chk({tag, "_cnt_branch"}, bus.cnt_branch, exp_br);
    chk({tag, "_cnt_taken"},  bus.cnt_taken,  exp_tk);
  endtask

  // One wrong-path op offered while squashing; it must vanish.
  task automatic squash_slot(input logic exp_ov, input logic exp_sq);
    @(negedge clk);
    drive(2'b01, 3'b000, 32'h40, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("sq_in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk("sq_out_valid", {31'd0, bus.out_valid},      {31'd0, exp_ov});
    chk("sq_redirect",  {31'd0, bus.redirect_valid}, 32'd0);
    chk("sq_squash",    {31'd0, bus.squash},         {31'd0, exp_sq});
    check_counters("sq");
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_out_valid"}, {31'd0, bus.out_valid},      32'd0);
    chk({tag, "_redirect"},  {31'd0, bus.redirect_valid}, 32'd0);
    chk({tag, "_squash"},    {31'd0, bus.squash},         32'd0);
    chk({tag, "_exc"},       {31'd0, bus.out_exc},        32'd0);
    chk({tag, "_cause"},     {30'd0, bus.out_cause},      32'd0);
    chk({tag, "_rd_we"},     {31'd0, bus.out_rd_we},      32'd0);
    chk({tag, "_link"},      bus.out_link,                32'd0);
    chk({tag, "_tval"},      bus.out_tval,                32'd0);
    chk({tag, "_rpc"},       bus.redirect_pc,             32'd0);
    chk({tag, "_cnt_br"},    bus.cnt_branch,              32'd0);
    chk({tag, "_cnt_tk"},    bus.cnt_taken,               32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            op     f3      pc            imm           rs1           eq    lts   ltu   taken exc   cause  tval          rd_we link          redir rpc
    vecs[0]  = '{2'b00, 3'b000, 32'h0000_0100, 32'h0000_0020, 32'h0,       1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 32'h0,        1'b0, 32'h0000_0104, 1'b1, 32'h0000_0120};
    vecs[1]  = '{2'b00, 3'b110, 32'h0000_0200, 32'h0000_0040, 32'h0,       1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0,        1'b0, 32'h0000_0204, 1'b0, 32'h0};
    vecs[2]  = '{2'b10, 3'b000, 32'h0000_0300, 32'h0000_0004, 32'h0000_2003, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b01, 32'h0000_2006, 1'b0, 32'h0000_0304, 1'b0, 32'h0};
    vecs[3]  = '{2'b01, 3'b000, 32'h0000_0400, 32'hFFFF_FFF8, 32'h0,       1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 32'h0,        1'b1, 32'h0000_0404, 1'b1, 32'h0000_03F8};
    vecs[4]  = '{2'b00, 3'b010, 32'h0000_0500, 32'h0000_0010, 32'h0,       1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 32'h0000_0500, 1'b0, 32'h0000_0504, 1'b0, 32'h0};
    vecs[5]  = '{2'b00, 3'b001, 32'h0000_0600, 32'h0000_0010, 32'h0,       1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0,        1'b0, 32'h0000_0604, 1'b0, 32'h0};
    vecs[6]  = '{2'b00, 3'b001, 32'h0000_0700, 32'h0000_0010, 32'h0,       1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 32'h0,        1'b0, 32'h0000_0704, 1'b1, 32'h0000_0710};
    vecs[7]  = '{2'b00, 3'b100, 32'h0000_0800, 32'hFFFF_FF00, 32'h0,       1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 32'h0,        1'b0, 32'h0000_0804, 1'b1, 32'h0000_0700};
    vecs[8]  = '{2'b00, 3'b101, 32'h0000_0900, 32'h0000_0010, 32'h0,       1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0,        1'b0, 32'h0000_0904, 1'b0, 32'h0};
    vecs[9]  = '{2'b00, 3'b111, 32'h0000_0A00, 32'h0000_0008, 32'h0,       1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 32'h0,        1'b0, 32'h0000_0A04, 1'b1, 32'h0000_0A08};
    vecs[10] = '{2'b11, 3'b000, 32'h0000_0B00, 32'h0000_0010, 32'h0,       1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 32'h0000_0B00, 1'b0, 32'h0000_0B04, 1'b0, 32'h0};
    vecs[11] = '{2'b10, 3'b000, 32'h0000_0C00, 32'h0000_0011, 32'h0000_1000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 32'h0,      1'b1, 32'h0000_0C04, 1'b1, 32'h0000_1010};
    vecs[12] = '{2'b00, 3'b011, 32'h0000_0D00, 32'h0000_0010, 32'h0,       1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 32'h0000_0D00, 1'b0, 32'h0000_0D04, 1'b0, 32'h0};
    vecs[13] = '{2'b00, 3'b000, 32'h0000_0E00, 32'h0000_0002, 32'h0,       1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b01, 32'h0000_0E02, 1'b0, 32'h0000_0E04, 1'b0, 32'h0};
    vecs[14] = '{2'b01, 3'b000, 32'hFFFF_FFFC, 32'h0000_0008, 32'h0,       1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 32'h0,        1'b1, 32'h0000_0000, 1'b1, 32'h0000_0004};

    bus.in_valid  = 1'b0;
    bus.in_op     = 2'b00;
    bus.in_funct3 = 3'b000;
    bus.in_pc     = '0;
    bus.in_imm    = '0;
    bus.in_rs1    = '0;
    bus.cmp_eq    = 1'b0;
    bus.cmp_lt_s  = 1'b0;
    bus.cmp_lt_u  = 1'b0;
    bus.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    chk("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven ops, each followed by the wrong-path drain when taken.
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      bus.out_ready = 1'b1;
      drive_vec(vecs[i]);
      chk("in_ready", {31'd0, bus.in_ready}, 32'd1);
      sb.push_back(vecs[i]);
      exp_br++;
      if (vecs[i].taken) exp_tk++;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      chk("redirect_valid", {31'd0, bus.redirect_valid}, {31'd0, vecs[i].redir});
      if (vecs[i].redir) chk("redirect_pc", bus.redirect_pc, vecs[i].rpc);
      check_result();
      chk("squash", {31'd0, bus.squash}, {31'd0, vecs[i].taken});
      check_counters("vec");
      if (vecs[i].taken) begin
        for (int k = 0; k < FLUSH; k++) begin
          squash_slot(1'b0, (k < FLUSH - 1));
        end
      end
    end

    // Stalled taken JAL: fields hold, redirect pulses once, squash drains
    // even while writeback is stalled.
    @(negedge clk);
    bus.out_ready = 1'b0;
    drive(2'b01, 3'b000, 32'h0000_1000, 32'h0000_0100, 32'h0, 1'b0, 1'b0, 1'b0);
    sb.push_back('{2'b01, 3'b000, 32'h1000, 32'h100, 32'h0, 1'b0, 1'b0, 1'b0,
                   1'b1, 1'b0, 2'b00, 32'h0, 1'b1, 32'h0000_1004, 1'b1, 32'h0000_1100});
    exp_br++;
    exp_tk++;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk("stall_redirect", {31'd0, bus.redirect_valid}, 32'd1);
    chk("stall_rpc", bus.redirect_pc, 32'h0000_1100);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk("stall_out_valid", {31'd0, bus.out_valid},      32'd1);
      chk("stall_link",      bus.out_link,                32'h0000_1004);
      chk("stall_rd_we",     {31'd0, bus.out_rd_we},      32'd1);
      chk("stall_redirect0", {31'd0, bus.redirect_valid}, 32'd0);
      chk("stall_squash",    {31'd0, bus.squash},         32'd1);
    end
    squash_slot(1'b1, 1'b1);
    chk("stall_link_kept", bus.out_link, 32'h0000_1004);
    @(negedge clk);
    bus.out_ready = 1'b1;
    check_result();
    @(posedge clk);
    #1;
    chk("stall_drained", {31'd0, bus.out_valid}, 32'd0);
    squash_slot(1'b0, 1'b0);

    // Backpressure in RUN, then accept-while-handshaking with no bubble.
    @(negedge clk);
    bus.out_ready = 1'b0;
    drive(2'b00, 3'b001, 32'h0000_2000, 32'h0000_0010, 32'h0, 1'b1, 1'b0, 1'b0);
    sb.push_back('{2'b00, 3'b001, 32'h2000, 32'h10, 32'h0, 1'b1, 1'b0, 1'b0,
                   1'b0, 1'b0, 2'b00, 32'h0, 1'b0, 32'h0000_2004, 1'b0, 32'h0});
    exp_br++;
    @(posedge clk);
    #1;
    chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
    drive(2'b00, 3'b000, 32'h0000_3000, 32'h0000_0010, 32'h0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("bp_link_held", bus.out_link, 32'h0000_2004);
    check_counters("bp");
    @(negedge clk);
    bus.out_ready = 1'b1;
    check_result();
    sb.push_back('{2'b00, 3'b000, 32'h3000, 32'h10, 32'h0, 1'b0, 1'b0, 1'b0,
                   1'b0, 1'b0, 2'b00, 32'h0, 1'b0, 32'h0000_3004, 1'b0, 32'h0});
    exp_br++;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check_result();
    check_counters("b2b");
    @(negedge clk);
    @(posedge clk);
    #1;

    // Reset while squashing with a stalled result pending.
    @(negedge clk);
    bus.out_ready = 1'b0;
    drive(2'b00, 3'b000, 32'h0000_0100, 32'h0000_0020, 32'h0, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk("rst_pre_squash", {31'd0, bus.squash}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    exp_br = 0;
    exp_tk = 0;

    // First op after reset is resolved normally in RUN.
    @(negedge clk);
    bus.out_ready = 1'b1;
    drive(2'b01, 3'b000, 32'h0000_0040, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    sb.push_back('{2'b01, 3'b000, 32'h40, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0,
                   1'b1, 1'b0, 2'b00, 32'h0, 1'b1, 32'h0000_0044, 1'b1, 32'h0000_0040});
    exp_br++;
    exp_tk++;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk("post_rst_redirect", {31'd0, bus.redirect_valid}, 32'd1);
    chk("post_rst_rpc", bus.redirect_pc, 32'h0000_0040);
    check_result();
    check_counters("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
